// File: rtl/multi_seq_det.sv
// Multi-channel symbol sequence detector sharing one history shift register.
// Define SEQDET_CNT_EN to build saturating per-channel match counters.
module multi_seq_det #(
    parameter  int unsigned SYM_W = 2,
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned NPAT  = 2,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned IDX_W = (NPAT > 1) ? $clog2(NPAT) : 1,
    localparam int unsigned LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [SYM_W-1:0]         in_sym,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_idx,
    input  logic [DEPTH*SYM_W-1:0]   cfg_pat,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     cfg_ovl,
    output logic [NPAT-1:0]          match,
    output logic [NPAT*CNT_W-1:0]    match_cnt
);

    localparam int unsigned K_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HIST_N = (DEPTH > 1) ? DEPTH - 1 : 1;
    localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'((DEPTH < 3) ? DEPTH : 3);
    localparam logic [K_W-1:0]   FILL_MAX = K_W'(DEPTH - 1);

    typedef logic [SYM_W-1:0] sym_t;
    typedef enum logic {ST_FILL, ST_ARMED} ch_state_e;

    sym_t             hist_q  [HIST_N];
    sym_t             hist_d  [HIST_N];
    sym_t             pat_q   [NPAT][DEPTH];
    sym_t             pat_d   [NPAT][DEPTH];
    logic [LEN_W-1:0] len_q   [NPAT];
    logic [LEN_W-1:0] len_d   [NPAT];
    logic [K_W-1:0]   fill_q  [NPAT];
    logic [K_W-1:0]   fill_d  [NPAT];
    ch_state_e        state_q [NPAT];
    ch_state_e        state_d [NPAT];
    logic [NPAT-1:0]  ovl_q, ovl_d;
    logic [NPAT-1:0]  match_q, match_d;
    logic [NPAT-1:0]  hit_c;

    // Channel is armed once enough usable history precedes the next symbol.
    function automatic ch_state_e arm_state(input logic [K_W-1:0] f, input logic [LEN_W-1:0] l);
        if (l == '0) begin
            return ST_FILL;
        end
        return ((32'(f) + 32'd1) >= 32'(l)) ? ST_ARMED : ST_FILL;
    endfunction

    function automatic sym_t rst_sym(input int unsigned p, input int unsigned k);
        sym_t s;
        s = '0;
        if (p == 0) begin
            case (k)
                0:       s = SYM_W'(1);
                1:       s = SYM_W'(3);
                2:       s = SYM_W'(2);
                default: s = '0;
            endcase
        end else if (p == 1) begin
            case (k)
                0:       s = SYM_W'(1);
                1:       s = SYM_W'(3);
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    function automatic logic [LEN_W-1:0] rst_len(input int unsigned p);
        return (p < 2) ? RST_LEN : '0;
    endfunction

    // Sequence compare: current symbol is the last pattern symbol, history supplies the rest.
    always_comb begin
        hit_c = '0;
        for (int unsigned p = 0; p < NPAT; p++) begin
            if (len_q[p] != '0 && state_q[p] == ST_ARMED) begin
                hit_c[p] = (in_sym == pat_q[p][K_W'(32'(len_q[p]) - 32'd1)]);
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (i < 32'(len_q[p])) begin
                        if (hist_q[i-1] != pat_q[p][K_W'(32'(len_q[p]) - 32'd1 - i)]) begin
                            hit_c[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Next-state: history shift, per-channel fill/state, config writes, match pulse.
    always_comb begin
        hist_d  = hist_q;
        pat_d   = pat_q;
        len_d   = len_q;
        fill_d  = fill_q;
        state_d = state_q;
        ovl_d   = ovl_q;
        match_d = '0;

        if (clr) begin
            for (int unsigned i = 0; i < HIST_N; i++) begin
                hist_d[i] = '0;
            end
            for (int unsigned p = 0; p < NPAT; p++) begin
                fill_d[p] = '0;
            end
        end else if (in_valid) begin
            hist_d[0] = in_sym;
            for (int unsigned i = 1; i < HIST_N; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end

        for (int unsigned p = 0; p < NPAT; p++) begin
            if (cfg_we && cfg_idx == IDX_W'(p)) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    pat_d[p][k] = cfg_pat[k*SYM_W +: SYM_W];
                end
                len_d[p]  = (cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
                ovl_d[p]  = cfg_ovl;
                fill_d[p] = '0;
            end else if (!clr && in_valid) begin
                match_d[p] = hit_c[p];
                if (hit_c[p] && !ovl_q[p]) begin
                    fill_d[p] = '0;
                end else if (fill_q[p] != FILL_MAX) begin
                    fill_d[p] = fill_q[p] + K_W'(1);
                end
            end
            state_d[p] = arm_state(fill_d[p], len_d[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < HIST_N; i++) begin
                hist_q[i] <= '0;
            end
            for (int unsigned p = 0; p < NPAT; p++) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    pat_q[p][k] <= rst_sym(p, k);
                end
                len_q[p]   <= rst_len(p);
                fill_q[p]  <= '0;
                state_q[p] <= arm_state('0, rst_len(p));
            end
            ovl_q   <= '0;
            match_q <= '0;
        end else begin
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            ovl_q   <= ovl_d;
            match_q <= match_d;
        end
    end

    assign match = match_q;

`ifdef SEQDET_CNT_EN
    logic [CNT_W-1:0] cnt_q [NPAT];
    logic [CNT_W-1:0] cnt_d [NPAT];

    // Saturating counters advance together with the registered pulse.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned p = 0; p < NPAT; p++) begin
            if (clr) begin
                cnt_d[p] = '0;
            end else if (match_d[p] && cnt_q[p] != '1) begin
                cnt_d[p] = cnt_q[p] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NPAT; p++) begin
                cnt_q[p] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int unsigned p = 0; p < NPAT; p++) begin
            match_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_seq_det.sv
// Scoreboard bench for multi_seq_det: directed scenarios plus random traffic
// checked against a queue-based sequence model.
`timescale 1ns/1ps
module tb_multi_seq_det;

    localparam int unsigned SYM_W = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NPAT  = 3;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned LEN_W = 3;
    localparam int unsigned HMAX  = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;
`ifdef SEQDET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clr;
    logic                    in_valid;
    logic [SYM_W-1:0]        in_sym;
    logic                    cfg_we;
    logic [IDX_W-1:0]        cfg_idx;
    logic [DEPTH*SYM_W-1:0]  cfg_pat;
    logic [LEN_W-1:0]        cfg_len;
    logic                    cfg_ovl;
    logic [NPAT-1:0]         match;
    logic [NPAT*CNT_W-1:0]   match_cnt;

    multi_seq_det #(.SYM_W(SYM_W), .DEPTH(DEPTH), .NPAT(NPAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_sym(in_sym),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_ovl(cfg_ovl), .match(match), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NPAT-1:0]       m;
        logic [NPAT*CNT_W-1:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses[NPAT];
    int   base[NPAT];

    // Reference model: per channel, the symbols accepted since its last restart point.
    int mpat[NPAT][DEPTH];
    int mlen[NPAT];
    bit movl[NPAT];
    int muse[NPAT][HMAX];
    int mn[NPAT];
    int mcnt[NPAT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int p, input int s);
        int l;
        l = mlen[p];
        if (l == 0 || mn[p] < l - 1) return 1'b0;
        if (s != mpat[p][l-1]) return 1'b0;
        for (int j = 0; j < l - 1; j++) begin
            if (muse[p][mn[p] - (l - 1) + j] != mpat[p][j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_push(input int p, input int s);
        if (mn[p] == HMAX) begin
            for (int j = 0; j < HMAX - 1; j++) muse[p][j] = muse[p][j+1];
            mn[p] = HMAX - 1;
        end
        muse[p][mn[p]] = s;
        mn[p]++;
    endfunction

    function automatic void model_reset();
        int dflt[3];
        for (int p = 0; p < NPAT; p++) begin
            mn[p] = 0;
            mcnt[p] = 0;
            movl[p] = 1'b0;
            mlen[p] = (p < 2) ? 3 : 0;
            dflt[0] = 1;
            dflt[1] = 3;
            dflt[2] = (p == 0) ? 2 : 0;
            for (int k = 0; k < DEPTH; k++) mpat[p][k] = (k < 3) ? dflt[k] : 0;
        end
    endfunction

    // One stimulus cycle: apply inputs at negedge, push expected response, release after the edge.
    task automatic drive(input bit v, input int s, input bit we, input int idx,
                         input logic [7:0] pat, input int len, input bit ovl, input bit c);
        exp_t e;
        bit   hit;
        @(negedge clk);
        in_valid = v;
        in_sym   = SYM_W'(s);
        cfg_we   = we;
        cfg_idx  = IDX_W'(idx);
        cfg_pat  = pat;
        cfg_len  = LEN_W'(len);
        cfg_ovl  = ovl;
        clr      = c;
        e.m = '0;
        if (c) begin
            for (int p = 0; p < NPAT; p++) begin
                mn[p] = 0;
                mcnt[p] = 0;
            end
        end else begin
            for (int p = 0; p < NPAT; p++) begin
                if (we && idx == p) begin
                    mn[p] = 0;
                end else if (v) begin
                    hit = model_hit(p, s);
                    e.m[p] = hit;
                    if (hit && !movl[p]) mn[p] = 0;
                    else model_push(p, s);
                end
            end
        end
        if (we && idx < NPAT) begin
            mn[idx]   = 0;
            mlen[idx] = (len > DEPTH) ? DEPTH : len;
            movl[idx] = ovl;
            for (int k = 0; k < DEPTH; k++) mpat[idx][k] = int'(pat[k*SYM_W +: SYM_W]);
        end
        for (int p = 0; p < NPAT; p++) begin
            if (CNT_EN && e.m[p] && mcnt[p] < CMAX) mcnt[p]++;
            e.c[p*CNT_W +: CNT_W] = CNT_W'(mcnt[p]);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic sym(input int s);
        drive(1'b1, s, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0);
    endtask

    task automatic cfg(input int idx, input logic [7:0] pat, input int len, input bit ovl);
        drive(1'b0, 0, 1'b1, idx, pat, len, ovl, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b0, 0, 1'b0, 0, 8'h00, 0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        clr      = 1'b0;
        #1;
        chk("reset_match", 32'(match), 32'd0);
        chk("reset_cnt", 32'(match_cnt), 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic chk_pulses(input string name, input int e0, input int e1, input int e2);
        int ex[NPAT];
        wait_drain();
        ex[0] = e0;
        ex[1] = e1;
        ex[2] = e2;
        for (int p = 0; p < NPAT; p++) begin
            chk($sformatf("%s_pulses_ch%0d", name, p), 32'(pulses[p] - base[p]), 32'(ex[p]));
            base[p] = pulses[p];
        end
    endtask

    // Monitor: compares every registered output cycle that has a pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("match", 32'(match), 32'(e.m));
            chk("match_cnt", 32'(match_cnt), 32'(e.c));
            for (int p = 0; p < NPAT; p++) if (match[p]) pulses[p]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, failures %0d", n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_sym = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
        for (int p = 0; p < NPAT; p++) begin
            pulses[p] = 0;
            base[p] = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("por_match", 32'(match), 32'd0);
        chk("por_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default patterns on slots 0 and 1; slot 2 disabled.
        sym(1); sym(3); sym(2);
        sym(1); sym(3); sym(0);
        chk_pulses("defaults", 1, 1, 0);

        // Repeated symbol pattern, overlapping then non-overlapping.
        cfg(0, 8'h0A, 2, 1'b1);
        for (int i = 0; i < 4; i++) sym(2);
        chk_pulses("ovl_on", 3, 0, 0);
        cfg(0, 8'h0A, 2, 1'b0);
        for (int i = 0; i < 4; i++) sym(2);
        chk_pulses("ovl_off", 2, 0, 0);

        // Idle gaps between symbols do not break the sequence.
        cfg(0, 8'h2D, 3, 1'b0);
        sym(1); repeat (3) idle();
        sym(3); repeat (3) idle();
        sym(2);
        chk_pulses("gaps", 1, 0, 0);

        // Config write colliding with the final symbol suppresses the match.
        sym(1); sym(3);
        drive(1'b1, 2, 1'b1, 0, 8'h2D, 3, 1'b0, 1'b0);
        sym(1); sym(3); sym(2);
        chk_pulses("cfg_collide", 1, 0, 0);

        // Oversized length is clamped to DEPTH.
        cfg(1, 8'hE4, 7, 1'b0);
        sym(0); sym(1); sym(2); sym(3);
        chk_pulses("len_clamp", 0, 1, 0);

        // Counter saturation, clear, and clear beating a same-cycle symbol.
        do_clr();
        for (int i = 0; i < 5; i++) begin
            sym(1); sym(3); sym(2);
        end
        chk_pulses("saturate", 5, 0, 0);
        chk("cnt_sat_ch0", 32'(match_cnt[CNT_W-1:0]), CNT_EN ? 32'd3 : 32'd0);
        do_clr();
        wait_drain();
        chk("cnt_clr_ch0", 32'(match_cnt[CNT_W-1:0]), 32'd0);
        sym(1); sym(3);
        drive(1'b1, 2, 1'b0, 0, 8'h00, 0, 1'b0, 1'b1);
        sym(2);
        chk_pulses("clr_wins", 0, 0, 0);

        // Asynchronous reset drops a live pulse and discards partial progress.
        sym(1); sym(3); sym(2);
        do_reset();
        sym(1); sym(3);
        do_reset();
        sym(2);
        chk_pulses("reset_mid", 1, 0, 0);

        // Random traffic with occasional reconfiguration and clears.
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b1,
                      int'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'b0);
            end else if (r < 4) begin
                drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0, 0,
                      8'h00, 0, 1'b0, 1'b1);
            end else if (r < 25) begin
                idle();
            end else begin
                sym(int'($urandom_range(0, 3)));
            end
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
